mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 21 ++
 rtl/Register.sv | 20 ++
 rtl/wb_select.sv | 28 ++
 rtl/mem_access_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   state_t          : FSM state encoding (IDLE / ACCESS)
//   SEL_*            : write-back select codes carried on reg_data_sel
//   DEFAULT_TIMEOUT  : default bound on data-memory ack wait
//   WAIT_CNT_W       : width of the ack wait counter
package mem_access_stage_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;
    localparam logic [1:0] SEL_SLT = 2'b11;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/Register.sv
// Generic synchronous register used for pipeline boundaries.
//   clk, rst  : rising-edge clock, synchronous active-high clear
//   load_en   : capture d when high
//   d / q     : word_len-bit data in / out
module Register #(
    parameter int word_len = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en,
    input  logic [word_len-1:0] d,
    output logic [word_len-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)          q <= '0;
        else if (load_en) q <= d;
    end

endmodule

// File: rtl/wb_select.sv
// Write-back value multiplexer.
//   sel        : SEL_ALU / SEL_MEM / SEL_PC / SEL_SLT
//   alu_res, mem_rdata, next_pc : 32-bit candidates
//   less_than  : slt result bit, zero-extended for SEL_SLT
//   wb_data    : selected 32-bit write-back value
module wb_select
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic [31:0] alu_res,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] next_pc,
    input  logic        less_than,
    output logic [31:0] wb_data
);

    always_comb begin
        wb_data = alu_res;
        case (sel)
            SEL_ALU: wb_data = alu_res;
            SEL_MEM: wb_data = mem_rdata;
            SEL_PC:  wb_data = next_pc;
            SEL_SLT: wb_data = {31'b0, less_than};
            default: wb_data = alu_res;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls the front of the
// pipeline while waiting for ack, and drives the MEM/WB register.
//   clk, rst                      : clock, synchronous active-high reset
//   next_pc_in, alu_res_in, mem_write_data_in, reg_dest_in, less_than_in,
//   mem_write_en_in, mem_read_en_in, reg_write_en_in, reg_data_sel_in
//                                 : EX/MEM register fields
//   dmem_req/we/addr/wdata        : data-memory request
//   dmem_ack/rdata                : data-memory response
//   stall                         : freezes PC .. EX/MEM
//   wb_data_out/dest_out/write_en_out : registered MEM/WB outputs
//   misalign_err, timeout_err     : sticky error flags
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [4:0]  reg_dest_in,
    input  logic        less_than_in,
    input  logic        mem_write_en_in,
    input  logic        mem_read_en_in,
    input  logic        reg_write_en_in,
    input  logic [1:0]  reg_data_sel_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] wb_data_out,
    output logic [4:0]  wb_dest_out,
    output logic        wb_write_en_out,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state, state_nx;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Snapshot of the op taken when entering ACCESS
    logic [31:0] hold_addr, hold_wdata, hold_next_pc;
    logic [4:0]  hold_dest;
    logic [1:0]  hold_sel;
    logic        hold_we, hold_rwe, hold_lt;

    logic mem_op, misaligned, timeout_hit;
    logic stall_c, bubble, use_hold, latch, cnt_clr, cnt_inc, set_mis, set_to;

    logic [31:0] sel_val, wb_data_d;
    logic [4:0]  wb_dest_d;
    logic        wb_en_d;

    assign mem_op      = mem_read_en_in | mem_write_en_in;
    assign misaligned  = |alu_res_in[1:0];
    assign timeout_hit = (state == ST_ACCESS) && !dmem_ack && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        bubble   = 1'b1;
        use_hold = 1'b0;
        latch    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        set_mis  = 1'b0;
        set_to   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!mem_op) begin
                    bubble = 1'b0;
                end else if (misaligned) begin
                    set_mis = 1'b1;
                end else begin
                    stall_c  = 1'b1;
                    latch    = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                use_hold = 1'b1;
                if (dmem_ack) begin
                    bubble   = 1'b0;
                    state_nx = ST_IDLE;
                end else if (timeout_hit) begin
                    set_to   = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign stall = stall_c & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt     <= '0;
            hold_addr    <= '0;
            hold_wdata   <= '0;
            hold_next_pc <= '0;
            hold_dest    <= '0;
            hold_sel     <= '0;
            hold_we      <= 1'b0;
            hold_rwe     <= 1'b0;
            hold_lt      <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (cnt_clr)      wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
            if (latch) begin
                hold_addr    <= alu_res_in;
                hold_wdata   <= mem_write_data_in;
                hold_next_pc <= next_pc_in;
                hold_dest    <= reg_dest_in;
                hold_sel     <= reg_data_sel_in;
                hold_we      <= mem_write_en_in;   // write wins when both enables set
                hold_rwe     <= reg_write_en_in;
                hold_lt      <= less_than_in;
            end
            if (set_mis) misalign_err <= 1'b1;
            if (set_to)  timeout_err  <= 1'b1;
        end
    end

    assign dmem_req   = (state == ST_ACCESS);
    assign dmem_we    = dmem_req & hold_we;
    assign dmem_addr  = dmem_req ? hold_addr  : '0;
    assign dmem_wdata = dmem_req ? hold_wdata : '0;

    wb_select u_wb_select (
        .sel       (use_hold ? hold_sel     : reg_data_sel_in),
        .alu_res   (use_hold ? hold_addr    : alu_res_in),
        .mem_rdata (dmem_rdata),
        .next_pc   (use_hold ? hold_next_pc : next_pc_in),
        .less_than (use_hold ? hold_lt      : less_than_in),
        .wb_data   (sel_val)
    );

    // A bubble keeps data/dest and only drops the write enable; stores never write back.
    assign wb_data_d = bubble ? wb_data_out : sel_val;
    assign wb_dest_d = bubble ? wb_dest_out : (use_hold ? hold_dest : reg_dest_in);
    assign wb_en_d   = bubble ? 1'b0 : (use_hold ? (hold_rwe & ~hold_we) : reg_write_en_in);

    Register #(.word_len(32)) u_wb_data (
        .clk(clk), .rst(rst), .load_en(1'b1), .d(wb_data_d), .q(wb_data_out)
    );
    Register #(.word_len(5)) u_wb_dest (
        .clk(clk), .rst(rst), .load_en(1'b1), .d(wb_dest_d), .q(wb_dest_out)
    );
    Register #(.word_len(1)) u_wb_en (
        .clk(clk), .rst(rst), .load_en(1'b1), .d(wb_en_d), .q(wb_write_en_out)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc_in, alu_res_in, mem_write_data_in;
    logic [4:0]  reg_dest_in;
    logic        less_than_in, mem_write_en_in, mem_read_en_in, reg_write_en_in;
    logic [1:0]  reg_data_sel_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_dest_out;
    logic        wb_write_en_out, misalign_err, timeout_err;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
    } wb_t;
    wb_t exp_q[$];

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .next_pc_in(next_pc_in), .alu_res_in(alu_res_in), .mem_write_data_in(mem_write_data_in),
        .reg_dest_in(reg_dest_in), .less_than_in(less_than_in),
        .mem_write_en_in(mem_write_en_in), .mem_read_en_in(mem_read_en_in),
        .reg_write_en_in(reg_write_en_in), .reg_data_sel_in(reg_data_sel_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .wb_data_out(wb_data_out), .wb_dest_out(wb_dest_out), .wb_write_en_out(wb_write_en_out),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every write-back the DUT presents must match the queue head.
    always @(negedge clk) begin : monitor
        wb_t e;
        if (!rst && wb_write_en_out) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got data=%h dest=%0d, required no write-back",
                         wb_data_out, wb_dest_out);
            end else begin
                e = exp_q.pop_front();
                if (wb_data_out !== e.data || wb_dest_out !== e.dest) begin
                    fails++;
                    $display("FAIL wb_data: got data=%h dest=%0d, required data=%h dest=%0d",
                             wb_data_out, wb_dest_out, e.data, e.dest);
                end
            end
        end
    end

    task automatic idle_inputs();
        mem_read_en_in  = 1'b0;
        mem_write_en_in = 1'b0;
        reg_write_en_in = 1'b0;
        alu_res_in      = 32'h0;
        reg_data_sel_in = SEL_ALU;
    endtask

    // Single-cycle non-memory op; exp is the hand-computed write-back value.
    task automatic alu_op(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] npc,
                          input logic lt, input logic [4:0] dest, input logic rwe,
                          input logic [31:0] exp);
        reg_data_sel_in = sel;
        alu_res_in      = alu;
        next_pc_in      = npc;
        less_than_in    = lt;
        reg_dest_in     = dest;
        reg_write_en_in = rwe;
        if (rwe) exp_q.push_back('{data: exp, dest: dest});
        @(negedge clk);
        chk("alu_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Memory op; ack is raised in cycle ack_at (cycle 0 = issue cycle, -1 = never).
    // Inputs are held while stall is high, mimicking a frozen EX/MEM register.
    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] dest, input int ack_at,
                          input logic [31:0] rdata, output int n_stall, output int n_req);
        logic held;
        n_stall = 0;
        n_req   = 0;
        held    = 1'b1;
        mem_read_en_in    = rd;
        mem_write_en_in   = wr;
        alu_res_in        = addr;
        mem_write_data_in = wdata;
        reg_dest_in       = dest;
        reg_write_en_in   = 1'b1;
        reg_data_sel_in   = SEL_MEM;
        for (int c = 0; c < 8; c++) begin
            dmem_ack   = (c == ack_at);
            dmem_rdata = (c == ack_at) ? rdata : 32'h0;
            @(negedge clk);
            if (stall)    n_stall++;
            if (dmem_req) begin
                n_req++;
                chk("req_addr",  dmem_addr,  addr);
                chk("req_wdata", dmem_wdata, wdata);
                chk("req_we",    {31'b0, dmem_we}, {31'b0, wr});
            end
            if (!stall) held = 1'b0;
            @(posedge clk); #1;
            if (!held) idle_inputs();
        end
        dmem_ack = 1'b0;
    endtask

    int ns, nr;

    initial begin
        rst = 1'b1;
        next_pc_in = 32'h0; mem_write_data_in = 32'h0; reg_dest_in = 5'd0; less_than_in = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req",   {31'b0, dmem_req}, 32'd0);
        chk("rst_addr",  dmem_addr, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_wb",    {wb_data_out[26:0], wb_dest_out}, 32'd0);
        chk("rst_errs",  {30'b0, misalign_err, timeout_err}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back ALU / PC / SLT write-backs, then one with no register write
        alu_op(SEL_ALU, 32'h0000_1234, 32'h0,      1'b0, 5'd5, 1'b1, 32'h0000_1234);
        alu_op(SEL_PC,  32'h0000_0044, 32'h0000_0040, 1'b0, 5'd7, 1'b1, 32'h0000_0040);
        alu_op(SEL_SLT, 32'hFFFF_FFF0, 32'h0,      1'b1, 5'd8, 1'b1, 32'h0000_0001);
        alu_op(SEL_ALU, 32'h0000_5555, 32'h0,      1'b0, 5'd9, 1'b0, 32'h0);

        // Load with ack in the third ACCESS cycle
        exp_q.push_back('{data: 32'hDEAD_BEEF, dest: 5'd10});
        mem_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd10, 3, 32'hDEAD_BEEF, ns, nr);
        chk("load_stall_cycles", ns, 32'd3);
        chk("load_req_cycles",   nr, 32'd3);

        // Store: no write-back even with reg_write set
        mem_op(1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_0001, 5'd11, 2, 32'h0, ns, nr);
        chk("store_stall_cycles", ns, 32'd2);
        chk("store_req_cycles",   nr, 32'd2);
        chk("store_no_wb", {31'b0, wb_write_en_out}, 32'd0);

        // Both enables: behaves as a store
        mem_op(1'b1, 1'b1, 32'h0000_0204, 32'h1357_9BDF, 5'd12, 1, 32'h7777_7777, ns, nr);
        chk("both_req_cycles", nr, 32'd1);

        // Misaligned load
        mem_op(1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd13, -1, 32'h0, ns, nr);
        chk("mis_stall_cycles", ns, 32'd0);
        chk("mis_req_cycles",   nr, 32'd0);
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk("mis_no_to", {31'b0, timeout_err}, 32'd0);

        // Load with no ack: aborts after 4 ACCESS cycles
        mem_op(1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd14, -1, 32'h0, ns, nr);
        chk("to_stall_cycles", ns, 32'd4);
        chk("to_req_cycles",   nr, 32'd4);
        chk("to_err", {31'b0, timeout_err}, 32'd1);
        chk("to_idle_req", {31'b0, dmem_req}, 32'd0);
        chk("mis_err_sticky", {31'b0, misalign_err}, 32'd1);

        // Sticky errors do not block later ops
        alu_op(SEL_ALU, 32'h0000_00AB, 32'h0, 1'b0, 5'd3, 1'b1, 32'h0000_00AB);
        exp_q.push_back('{data: 32'h0BAD_F00D, dest: 5'd15});
        mem_op(1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd15, 1, 32'h0BAD_F00D, ns, nr);
        chk("post_err_load_stall", ns, 32'd1);
        chk("post_err_load_req",   nr, 32'd1);

        // Reset during the second ACCESS cycle aborts the load
        mem_read_en_in = 1'b1; alu_res_in = 32'h0000_0500; reg_dest_in = 5'd16;
        reg_write_en_in = 1'b1; reg_data_sel_in = SEL_MEM;
        @(posedge clk); #1;            // ACCESS cycle 1
        @(posedge clk); #1 rst = 1'b1; // ACCESS cycle 2
        @(negedge clk);
        chk("rst_mid_req_before", {31'b0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rst_mid_req",   {31'b0, dmem_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        chk("rst_mid_wb",    {wb_data_out[25:0], wb_dest_out, wb_write_en_out}, 32'd0);
        chk("rst_mid_errs",  {30'b0, misalign_err, timeout_err}, 32'd0);
        chk("rst_mid_addr",  dmem_addr, 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
            chk("late_ack_wb",  {31'b0, wb_write_en_out}, 32'd0);
        end
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
